// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM burst RAM slave.
// The LFSR helper is only used when AVMM_SLAVE_WAIT_INJECT_EN is defined.
package avmm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR_BURST = 2'd3
  } avmm_slv_state_t;

  localparam int          BYTES_PER_BEAT = 16;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;

  // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/avmm_ram_bank.sv
// Single-port byte-enable RAM with a registered read port (one cycle latency).
// Contents are never reset; a write cycle leaves o_rdata unchanged.
module avmm_ram_bank
  import avmm_pkg::*;
#(
  parameter int DATA_W = BYTES_PER_BEAT * 8,
  parameter int DEPTH  = 8192,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avmm_burst_ram_slave.sv
// Avalon-MM burst slave fronting a single-port RAM; reads return beats 2 cycles after accept.
// Define AVMM_SLAVE_WAIT_INJECT_EN to add LFSR-driven stalls in IDLE/WR_BURST.
module avmm_burst_ram_slave
  import avmm_pkg::*;
#(
  parameter int          SDRAM_W     = BYTES_PER_BEAT * 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH_WORDS = 8192
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          address,
  input  logic [10:0]          burstcount,
  input  logic                 read,
  input  logic                 write,
  input  logic [SDRAM_W-1:0]   writedata,
  input  logic [SDRAM_W/8-1:0] byteenable,
  output logic                 waitrequest,
  output logic [SDRAM_W-1:0]   readdata,
  output logic                 readdatavalid
);

  localparam int BEAT_BYTES = SDRAM_W / 8;
  localparam int SHIFT      = $clog2(BEAT_BYTES);
  localparam int AW         = $clog2(DEPTH_WORDS);
  localparam int IW         = 34;
  localparam logic signed [IW-1:0] DEPTH_S = IW'(DEPTH_WORDS);
  localparam logic signed [IW-1:0] ZERO_S  = '0;
  localparam logic signed [IW-1:0] ONE_S   = IW'(1);

  // Beat indices are kept wide and signed so bursts never wrap into the array.
  function automatic logic idx_in_range(input logic signed [IW-1:0] idx);
    return (idx >= ZERO_S) && (idx < DEPTH_S);
  endfunction

  avmm_slv_state_t       r_state;
  logic                  r_waitreq;
  logic signed [IW-1:0]  r_idx;
  logic [10:0]           r_remain;
  logic                  r_vld_p1;
  logic                  r_oor_p1;

  logic signed [IW-1:0]  w_byte_off;
  logic signed [IW-1:0]  w_cmd_idx;
  logic [10:0]           w_cmd_len;
  logic                  w_idle_wr;
  logic                  w_idle_rd;
  logic                  w_burst_wr;
  logic                  w_inject;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [AW-1:0]         w_ram_addr;
  logic [SDRAM_W-1:0]    w_ram_rdata;

  assign w_byte_off = $signed({2'b00, address}) - $signed({2'b00, BASE_ADDR});
  assign w_cmd_idx  = w_byte_off >>> SHIFT;
  assign w_cmd_len  = (burstcount == 11'd0) ? 11'd1 : burstcount;

  // A simultaneous read and write in IDLE is taken as a write.
  assign w_idle_wr  = (r_state == IDLE) && write && !r_waitreq;
  assign w_idle_rd  = (r_state == IDLE) && read && !write && !r_waitreq;
  assign w_burst_wr = (r_state == WR_BURST) && write && !r_waitreq;

`ifdef AVMM_SLAVE_WAIT_INJECT_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  assign w_lfsr_nxt = lfsr16_next(r_lfsr);
  assign w_inject   = w_lfsr_nxt[0];

  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= w_lfsr_nxt;
  end
`else
  assign w_inject = 1'b0;
`endif

  // RAM port arbitration: the FSM state guarantees at most one requester per cycle.
  always_comb begin
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = '0;
    if (w_idle_wr) begin
      w_ram_en   = idx_in_range(w_cmd_idx);
      w_ram_we   = 1'b1;
      w_ram_addr = w_cmd_idx[AW-1:0];
    end else if (w_burst_wr) begin
      w_ram_en   = idx_in_range(r_idx);
      w_ram_we   = 1'b1;
      w_ram_addr = r_idx[AW-1:0];
    end else if (r_state == RD_ISSUE) begin
      w_ram_en   = idx_in_range(r_idx);
      w_ram_addr = r_idx[AW-1:0];
    end
    if (!rst_n) w_ram_en = 1'b0;
  end

  avmm_ram_bank #(
    .DATA_W (SDRAM_W),
    .DEPTH  (DEPTH_WORDS),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_be    (byteenable),
    .i_wdata (writedata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_waitreq <= 1'b0;
      r_idx     <= '0;
      r_remain  <= '0;
      r_vld_p1  <= 1'b0;
      r_oor_p1  <= 1'b0;
    end else begin
      r_vld_p1  <= 1'b0;
      r_oor_p1  <= 1'b0;
      r_waitreq <= w_inject;
      unique case (r_state)
        IDLE: begin
          if (w_idle_wr) begin
            if (w_cmd_len > 11'd1) begin
              r_state  <= WR_BURST;
              r_idx    <= w_cmd_idx + ONE_S;
              r_remain <= w_cmd_len - 11'd1;
            end
          end else if (w_idle_rd) begin
            r_state   <= RD_ISSUE;
            r_idx     <= w_cmd_idx;
            r_remain  <= w_cmd_len;
            r_waitreq <= 1'b1;
          end
        end
        RD_ISSUE: begin
          r_vld_p1  <= 1'b1;
          r_oor_p1  <= !idx_in_range(r_idx);
          r_idx     <= r_idx + ONE_S;
          r_remain  <= r_remain - 11'd1;
          r_waitreq <= 1'b1;
          if (r_remain == 11'd1) r_state <= RD_DRAIN;
        end
        RD_DRAIN: begin
          r_state <= IDLE;
        end
        WR_BURST: begin
          if (w_burst_wr) begin
            r_idx    <= r_idx + ONE_S;
            r_remain <= r_remain - 11'd1;
            if (r_remain == 11'd1) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output stage: RAM data is valid the cycle after issue, zeroed outside the array.
  assign waitrequest   = r_waitreq;
  assign readdatavalid = r_vld_p1;
  assign readdata      = (r_vld_p1 && !r_oor_p1) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_avmm_burst_ram_slave.sv
// Scoreboard bench for avmm_burst_ram_slave: a reference memory model predicts each
// read beat (data and cycle); a negedge monitor pops and compares.
module tb_avmm_burst_ram_slave;

  localparam int          W    = 128;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          D    = 8192;

  logic           clk;
  logic           rst_n;
  logic [31:0]    address;
  logic [10:0]    burstcount;
  logic           read;
  logic           write;
  logic [W-1:0]   writedata;
  logic [W/8-1:0] byteenable;
  logic           waitrequest;
  logic [W-1:0]   readdata;
  logic           readdatavalid;

  avmm_burst_ram_slave #(
    .SDRAM_W     (W),
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .burstcount    (burstcount),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mdl [int];
  logic [W-1:0] wdat [16];
  int           cyc = 0;
  int           n_total = 0;
  int           n_bad = 0;
  int           beats_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL global_timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mdl_read(input int i);
    if (i < 0 || i >= D || !mdl.exists(i)) return '0;
    return mdl[i];
  endfunction

  function automatic void mdl_write(input int i, input logic [W-1:0] d, input logic [W/8-1:0] be);
    logic [W-1:0] v;
    if (i < 0 || i >= D) return;
    v = mdl_read(i);
    for (int b = 0; b < W / 8; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    mdl[i] = v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (readdatavalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 128'(readdatavalid), '0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", readdata, e.data);
          chk("rd_cycle", 128'(cyc), 128'(e.cyc));
          beats_seen++;
        end
      end else begin
        chk("rdata_idle_zero", readdata, '0);
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (waitrequest && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("ready", 128'(waitrequest), '0);
  endtask

  task automatic do_write(input int idx, input int n, input logic [W/8-1:0] be,
                          input int gap_after, input int gap_len, input int abort_at);
    for (int k = 0; k < n; k++) begin
      address    = BASE + 32'(idx * 16);
      burstcount = 11'(n);
      writedata  = wdat[k];
      byteenable = be;
      write      = 1'b1;
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        write = 1'b0;
        return;
      end
      wait_ready();
      @(posedge clk); #1;
      mdl_write(idx + k, wdat[k], be);
      write = 1'b0;
      if (k == gap_after) repeat (gap_len) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_read(input int idx, input int n_cmd, input bit wait_done);
    int n;
    int g;
    n = (n_cmd == 0) ? 1 : n_cmd;
    wait_ready();
    address    = BASE + 32'(idx * 16);
    burstcount = 11'(n_cmd);
    read       = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back('{data: mdl_read(idx + k), cyc: cyc + 1 + k});
    if (!wait_done) return;
    chk("wr_stall_issue", 128'(waitrequest), 128'(1));
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      if (k < n) chk("wr_stall_burst", 128'(waitrequest), 128'(1));
      else       chk("wr_idle_after", 128'(waitrequest), '0);
    end
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("read_drained", 128'(exp_q.size()), '0);
  endtask

  initial begin
    int base_seen;
    int g;
    rst_n      = 1'b0;
    address    = '0;
    burstcount = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitreq", 128'(waitrequest), '0);
    chk("rst_vld", 128'(readdatavalid), '0);
    chk("rst_rdata", readdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write then read
    wdat[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_write(1, 1, '1, -1, 0, -1);
    do_read(1, 1, 1);

    // 8-beat preload word[i]=i, then burst read
    for (int i = 0; i < 8; i++) wdat[i] = 128'(i);
    do_write(0, 8, '1, -1, 0, -1);
    do_read(0, 8, 1);

    // 4-beat write with a 2-cycle gap after beat 1
    for (int i = 0; i < 4; i++) wdat[i] = {4{32'hC0DE_0000 + 32'(i)}};
    do_write(0, 4, '1, 1, 2, -1);
    do_read(0, 4, 1);

    // partial byte write
    wdat[0] = {16{8'hAA}};
    do_write(5, 1, '1, -1, 0, -1);
    wdat[0] = {16{8'h55}};
    do_write(5, 1, 16'h00FF, -1, 0, -1);
    do_read(5, 1, 1);

    // bursts crossing the top of the array must not wrap
    for (int i = 0; i < 4; i++) wdat[i] = {2{64'hFACE_0000_0000_0000 + 64'(i)}};
    do_write(D - 2, 4, '1, -1, 0, -1);
    do_read(D - 2, 4, 1);
    do_read(0, 2, 1);

    // address below BASE, and burstcount 0 treated as 1
    do_read(-1, 2, 1);
    do_read(1, 0, 1);

    // read and write together in IDLE: write wins, no read data
    wdat[0] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    address    = BASE + 32'(6 * 16);
    burstcount = 11'd1;
    writedata  = wdat[0];
    byteenable = '1;
    read       = 1'b1;
    write      = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    mdl_write(6, wdat[0], '1);
    read  = 1'b0;
    write = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    do_read(6, 1, 1);

    // write burst then immediate read of the same words
    for (int i = 0; i < 2; i++) wdat[i] = {4{32'h7000_0000 + 32'(i)}};
    do_write(10, 2, '1, -1, 0, -1);
    do_read(10, 2, 1);

    // reset aborts a write burst after two beats
    for (int i = 0; i < 4; i++) wdat[i] = {4{32'h0BAD_0000 + 32'(i)}};
    do_write(0, 4, '1, -1, 0, 2);
    repeat (2) begin
      @(posedge clk); #1;
    end
    do_read(0, 4, 1);

    // reset after the third beat of a 16-beat read
    for (int i = 0; i < 16; i++) wdat[i] = {4{32'h5100_0000 + 32'(i)}};
    do_write(32, 16, '1, -1, 0, -1);
    base_seen = beats_seen;
    do_read(32, 16, 0);
    g = 0;
    while (beats_seen < base_seen + 3 && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    chk("rst_after_3beats", 128'(beats_seen - base_seen), 128'(3));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_vld", 128'(readdatavalid), '0);
    chk("midrst_waitreq", 128'(waitrequest), '0);
    chk("midrst_rdata", readdata, '0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    do_read(32, 16, 1);

    chk("scoreboard_empty", 128'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
